// File: rtl/gci_std_display_vram_arbiter.sv
// VRAM arbiter between the display request controller (session master) and the refresh fetcher.
// Forwards master accesses with zero latency and returns read data through a credit-limited FIFO.
module gci_std_display_vram_arbiter #(
    parameter int P_MEM_ADDR_N = 23,
    parameter int P_RBUF_DEPTH = 4,
    parameter int P_RBUF_N     = 2
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    // Session master
    input  logic                    iIF_REQ,
    output logic                    oIF_ACK,
    input  logic                    iIF_FINISH,
    output logic                    oIF_BREAK,
    input  logic                    iIF_ENA,
    input  logic                    iIF_RW,
    input  logic [P_MEM_ADDR_N-1:0] iIF_ADDR,
    input  logic [7:0]              iIF_R,
    input  logic [7:0]              iIF_G,
    input  logic [7:0]              iIF_B,
    output logic                    oIF_BUSY,
    output logic                    oIF_VALID,
    input  logic                    iIF_BUSY,
    output logic [31:0]             oIF_DATA,
    // Refresh fetcher
    input  logic                    iPRI_REQ,
    output logic                    oPRI_GNT,
    // VRAM port
    output logic                    oMEM_ENA,
    output logic                    oMEM_RW,
    output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
    output logic [23:0]             oMEM_DATA,
    input  logic                    iMEM_BUSY,
    input  logic                    iMEM_VALID,
    input  logic [31:0]             iMEM_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_PRI    = 2'd3
    } state_t;

    localparam logic [P_RBUF_N+1:0] L_DEPTH = (P_RBUF_N+2)'(P_RBUF_DEPTH);

    state_t                r_state;
    logic                  r_ack;
    logic                  r_break;
    logic                  r_pri_gnt;
    logic [P_RBUF_N:0]     r_outstanding;
    logic [P_RBUF_N:0]     r_count;
    logic [P_RBUF_N-1:0]   r_wptr;
    logic [P_RBUF_N-1:0]   r_rptr;
    logic [31:0]           r_rbuf [P_RBUF_DEPTH];

    logic [P_RBUF_N+1:0]   w_in_use;
    logic                  w_no_credit;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_rd_issue;
    logic                  w_ret;
    logic                  w_pop;

    // Credit covers reads still in flight plus results not yet taken, so a return can never overflow.
    assign w_in_use    = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_no_credit = (w_in_use >= L_DEPTH);
    assign w_busy      = (r_state != ST_ACTIVE) | r_break | iMEM_BUSY | w_no_credit;
    assign w_accept    = iIF_ENA & ~w_busy & ~iIF_FINISH;
    assign w_rd_issue  = w_accept & ~iIF_RW;
    // A return with nothing outstanding is a protocol error and is discarded.
    assign w_ret       = iMEM_VALID & (r_outstanding != '0);
    assign w_pop       = (r_count != '0) & ~iIF_BUSY;

    assign oIF_ACK   = r_ack;
    assign oIF_BREAK = r_break;
    assign oPRI_GNT  = r_pri_gnt;
    assign oIF_BUSY  = w_busy;
    assign oIF_VALID = w_pop;
    assign oIF_DATA  = r_rbuf[r_rptr];

    assign oMEM_ENA  = w_accept;
    assign oMEM_RW   = w_accept & iIF_RW;
    assign oMEM_ADDR = w_accept ? iIF_ADDR : '0;
    assign oMEM_DATA = w_accept ? {iIF_R, iIF_G, iIF_B} : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_break   <= 1'b0;
            r_pri_gnt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 1'b0;
                    if (iPRI_REQ) begin
                        r_state   <= ST_PRI;
                        r_pri_gnt <= 1'b1;
                    end else if (iIF_REQ) begin
                        r_state <= ST_ACTIVE;
                        r_ack   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    r_ack <= 1'b0;
                    if (iIF_FINISH) begin
                        r_state <= ST_DRAIN;
                        r_break <= 1'b0;
                    end else if (iPRI_REQ) begin
                        r_break <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        if (iPRI_REQ) begin
                            r_state   <= ST_PRI;
                            r_pri_gnt <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_PRI: begin
                    if (!iPRI_REQ) begin
                        r_state   <= ST_IDLE;
                        r_pri_gnt <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_break   <= 1'b0;
                    r_pri_gnt <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // NOTE: the small result buffer is reset so oIF_DATA reads zero after reset; larger RAMs would not be.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < P_RBUF_DEPTH; i++) begin
                r_rbuf[i] <= '0;
            end
        end else begin
            if (w_ret) begin
                r_rbuf[r_wptr] <= iMEM_DATA;
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_ret, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// Self-checking bench for gci_std_display_vram_arbiter: vector table for access forwarding,
// a latency-programmable memory responder, and an in-order read-data scoreboard.
module tb_gci_std_display_vram_arbiter;

    localparam int AW = 23;

    logic          iCLOCK = 1'b0;
    logic          inRESET;
    logic          iIF_REQ, iIF_FINISH, iIF_ENA, iIF_RW, iIF_BUSY;
    logic [AW-1:0] iIF_ADDR;
    logic [7:0]    iIF_R, iIF_G, iIF_B;
    logic          iPRI_REQ, iMEM_BUSY, iMEM_VALID;
    logic [31:0]   iMEM_DATA;
    logic          oIF_ACK, oIF_BREAK, oIF_BUSY, oIF_VALID, oPRI_GNT;
    logic          oMEM_ENA, oMEM_RW;
    logic [31:0]   oIF_DATA;
    logic [AW-1:0] oMEM_ADDR;
    logic [23:0]   oMEM_DATA;

    gci_std_display_vram_arbiter dut (
        .iCLOCK     (iCLOCK),
        .inRESET    (inRESET),
        .iIF_REQ    (iIF_REQ),
        .oIF_ACK    (oIF_ACK),
        .iIF_FINISH (iIF_FINISH),
        .oIF_BREAK  (oIF_BREAK),
        .iIF_ENA    (iIF_ENA),
        .iIF_RW     (iIF_RW),
        .iIF_ADDR   (iIF_ADDR),
        .iIF_R      (iIF_R),
        .iIF_G      (iIF_G),
        .iIF_B      (iIF_B),
        .oIF_BUSY   (oIF_BUSY),
        .oIF_VALID  (oIF_VALID),
        .iIF_BUSY   (iIF_BUSY),
        .oIF_DATA   (oIF_DATA),
        .iPRI_REQ   (iPRI_REQ),
        .oPRI_GNT   (oPRI_GNT),
        .oMEM_ENA   (oMEM_ENA),
        .oMEM_RW    (oMEM_RW),
        .oMEM_ADDR  (oMEM_ADDR),
        .oMEM_DATA  (oMEM_DATA),
        .iMEM_BUSY  (iMEM_BUSY),
        .iMEM_VALID (iMEM_VALID),
        .iMEM_DATA  (iMEM_DATA)
    );

    initial forever #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic          ena;
        logic          rw;
        logic [AW-1:0] addr;
        logic [7:0]    r, g, b;
        logic          mem_busy;
        logic          e_ena;
        logic          e_rw;
        logic          e_busy;
        logic [AW-1:0] e_addr;
        logic [23:0]   e_data;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          mem_lat   = 3;
    int          n_returns = 0;
    logic [31:0] mon_exp;
    pend_t       mon_p;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {8'h00, a[15:0] ^ 16'hBEEF, a[7:0] + 8'h3C};
    endfunction

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && pend_q.size() == 0) break;
            step();
        end
        check(name, 64'(exp_q.size() + pend_q.size()), 0);
    endtask

    // Memory model: returns reads in order, mem_lat cycles after acceptance.
    initial begin
        iMEM_VALID = 1'b0;
        iMEM_DATA  = '0;
        forever begin
            @(posedge iCLOCK);
            cyc++;
            #1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                iMEM_VALID = 1'b1;
                iMEM_DATA  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
                n_returns++;
            end else begin
                iMEM_VALID = 1'b0;
                iMEM_DATA  = '0;
            end
        end
    end

    // Scoreboard: expected data pushed at read issue, popped when the DUT presents a result.
    initial forever begin
        @(negedge iCLOCK);
        if (inRESET === 1'b1) begin
            if (oMEM_ENA && !oMEM_RW) begin
                mon_p.addr = oMEM_ADDR;
                mon_p.due  = cyc + mem_lat;
                pend_q.push_back(mon_p);
                exp_q.push_back(mem_word(oMEM_ADDR));
            end
            if (oIF_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rdata", oIF_DATA, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[5];
        int   waited;
        int   r0;

        vecs[0] = '{ena:1'b1, rw:1'b1, addr:23'h10,     r:8'h11, g:8'h22, b:8'h33, mem_busy:1'b0,
                    e_ena:1'b1, e_rw:1'b1, e_busy:1'b0, e_addr:23'h10,     e_data:24'h112233};
        vecs[1] = '{ena:1'b1, rw:1'b1, addr:23'h7FFFFF, r:8'hFF, g:8'h00, b:8'h80, mem_busy:1'b0,
                    e_ena:1'b1, e_rw:1'b1, e_busy:1'b0, e_addr:23'h7FFFFF, e_data:24'hFF0080};
        vecs[2] = '{ena:1'b0, rw:1'b1, addr:23'h20,     r:8'hAA, g:8'hBB, b:8'hCC, mem_busy:1'b0,
                    e_ena:1'b0, e_rw:1'b0, e_busy:1'b0, e_addr:23'h0,      e_data:24'h000000};
        vecs[3] = '{ena:1'b1, rw:1'b1, addr:23'h30,     r:8'hAA, g:8'hBB, b:8'hCC, mem_busy:1'b1,
                    e_ena:1'b0, e_rw:1'b0, e_busy:1'b1, e_addr:23'h0,      e_data:24'h000000};
        vecs[4] = '{ena:1'b1, rw:1'b1, addr:23'h0,      r:8'h01, g:8'h02, b:8'h03, mem_busy:1'b0,
                    e_ena:1'b1, e_rw:1'b1, e_busy:1'b0, e_addr:23'h0,      e_data:24'h010203};

        // NOTE: bench drives inputs with blocking assignments one time unit after the clock edge.
        inRESET = 1'b0; iIF_REQ = 1'b0; iIF_FINISH = 1'b0; iIF_ENA = 1'b0; iIF_RW = 1'b0;
        iIF_ADDR = '0; iIF_R = '0; iIF_G = '0; iIF_B = '0; iIF_BUSY = 1'b0;
        iPRI_REQ = 1'b0; iMEM_BUSY = 1'b0;
        repeat (3) @(posedge iCLOCK);
        #1 inRESET = 1'b1;

        @(negedge iCLOCK);
        check("rst_ack", oIF_ACK, 0);
        check("rst_break", oIF_BREAK, 0);
        check("rst_gnt", oPRI_GNT, 0);
        check("rst_valid", oIF_VALID, 0);
        check("rst_data", oIF_DATA, 0);
        check("rst_mem_ena", oMEM_ENA, 0);
        step();

        // T1: session grant and single-cycle ACK
        iIF_REQ = 1'b1;
        @(negedge iCLOCK); check("t1_ack_idle", oIF_ACK, 0);
        step(); iIF_REQ = 1'b0;
        @(negedge iCLOCK); check("t1_ack_pulse", oIF_ACK, 1);
        step();
        @(negedge iCLOCK); check("t1_ack_low", oIF_ACK, 0);
        step();

        // Forwarding table (row 0 is the T1 write)
        for (int i = 0; i < 5; i++) begin
            iIF_ENA = vecs[i].ena; iIF_RW = vecs[i].rw; iIF_ADDR = vecs[i].addr;
            iIF_R = vecs[i].r; iIF_G = vecs[i].g; iIF_B = vecs[i].b; iMEM_BUSY = vecs[i].mem_busy;
            @(negedge iCLOCK);
            check($sformatf("vec%0d_mem_ena", i), oMEM_ENA, vecs[i].e_ena);
            check($sformatf("vec%0d_mem_rw", i), oMEM_RW, vecs[i].e_rw);
            check($sformatf("vec%0d_mem_addr", i), oMEM_ADDR, vecs[i].e_addr);
            check($sformatf("vec%0d_mem_data", i), oMEM_DATA, vecs[i].e_data);
            check($sformatf("vec%0d_busy", i), oIF_BUSY, vecs[i].e_busy);
            step();
        end
        iIF_ENA = 1'b0; iMEM_BUSY = 1'b0;

        // T2: four back-to-back reads, latency 3; fifth waits for the first pop
        mem_lat = 3;
        for (int i = 0; i < 4; i++) begin
            iIF_ENA = 1'b1; iIF_RW = 1'b0; iIF_ADDR = 23'h100 + 23'(i);
            @(negedge iCLOCK); check($sformatf("t2_rd%0d_busy", i), oIF_BUSY, 0);
            step();
        end
        iIF_ADDR = 23'h104;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLOCK);
            if (i == 0) begin
                check("t2_fifth_busy", oIF_BUSY, 1);
                check("t2_pop_in_busy_cycle", oIF_VALID, 1);
            end
            if (!oIF_BUSY) break;
            waited++;
            step();
        end
        check("t2_wait_cycles", waited, 1);
        step(); iIF_ENA = 1'b0;
        wait_drain("t2_drain");

        // T3: master stalls while four reads return, then releases
        iIF_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iIF_ENA = 1'b1; iIF_RW = 1'b0; iIF_ADDR = 23'h200 + 23'(i);
            @(negedge iCLOCK); check($sformatf("t3_rd%0d_busy", i), oIF_BUSY, 0);
            step();
        end
        iIF_ENA = 1'b0;
        repeat (6) step();
        @(negedge iCLOCK);
        check("t3_full_busy", oIF_BUSY, 1);
        check("t3_full_no_valid", oIF_VALID, 0);
        step(); iIF_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLOCK);
            check($sformatf("t3_pop%0d", i), oIF_VALID, 1);
            if (i == 0) check("t3_busy_first_pop", oIF_BUSY, 1);
            step();
        end
        @(negedge iCLOCK);
        check("t3_empty_valid", oIF_VALID, 0);
        check("t3_empty_busy", oIF_BUSY, 0);
        step();

        // Access in FINISH cycle is dropped; session ends
        iIF_FINISH = 1'b1; iIF_ENA = 1'b1; iIF_RW = 1'b1; iIF_ADDR = 23'h40;
        @(negedge iCLOCK); check("finish_drop", oMEM_ENA, 0);
        step(); iIF_FINISH = 1'b0; iIF_ENA = 1'b0;
        step(); step();

        // T4: priority request breaks a session with two reads pending
        mem_lat = 8;
        iIF_REQ = 1'b1;
        step(); iIF_REQ = 1'b0;
        @(negedge iCLOCK); check("t4_ack", oIF_ACK, 1);
        r0 = n_returns;
        for (int i = 0; i < 2; i++) begin
            step();
            iIF_ENA = 1'b1; iIF_RW = 1'b0; iIF_ADDR = 23'h300 + 23'(i);
            @(negedge iCLOCK); check($sformatf("t4_rd%0d_busy", i), oIF_BUSY, 0);
        end
        step(); iIF_ENA = 1'b0; iPRI_REQ = 1'b1;
        @(negedge iCLOCK); check("t4_break_not_yet", oIF_BREAK, 0);
        step(); iIF_ENA = 1'b1; iIF_RW = 1'b1; iIF_ADDR = 23'h55;
        @(negedge iCLOCK);
        check("t4_break", oIF_BREAK, 1);
        check("t4_blocked_busy", oIF_BUSY, 1);
        check("t4_blocked_mem_ena", oMEM_ENA, 0);
        step(); iIF_ENA = 1'b0; iIF_FINISH = 1'b1;
        @(negedge iCLOCK);
        step(); iIF_FINISH = 1'b0;
        @(negedge iCLOCK);
        check("t4_drain_break_clr", oIF_BREAK, 0);
        check("t4_drain_no_gnt", oPRI_GNT, 0);
        for (int i = 0; i < 30; i++) begin
            if (oPRI_GNT) break;
            step();
            @(negedge iCLOCK);
        end
        check("t4_gnt", oPRI_GNT, 1);
        check("t4_returns_before_gnt", n_returns - r0, 2);
        step(); iIF_ENA = 1'b1; iIF_RW = 1'b1; iIF_ADDR = 23'h66;
        @(negedge iCLOCK); check("t4_pri_mem_ena", oMEM_ENA, 0);
        step(); iIF_ENA = 1'b0; iPRI_REQ = 1'b0;
        @(negedge iCLOCK); check("t4_gnt_held", oPRI_GNT, 1);
        step();
        @(negedge iCLOCK);
        check("t4_idle_gnt", oPRI_GNT, 0);
        check("t4_idle_ack", oIF_ACK, 0);
        step();
        check("t4_drained", 64'(exp_q.size()), 0);

        // T5: simultaneous requests in IDLE; priority wins
        iPRI_REQ = 1'b1; iIF_REQ = 1'b1;
        step();
        @(negedge iCLOCK);
        check("t5_gnt", oPRI_GNT, 1);
        check("t5_no_ack", oIF_ACK, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge iCLOCK); check($sformatf("t5_no_ack_%0d", i), oIF_ACK, 0);
        end
        step(); iPRI_REQ = 1'b0;
        @(negedge iCLOCK); check("t5_gnt_last", oPRI_GNT, 1);
        step();
        @(negedge iCLOCK);
        check("t5_idle_gnt", oPRI_GNT, 0);
        check("t5_idle_ack", oIF_ACK, 0);
        step();
        @(negedge iCLOCK); check("t5_ack", oIF_ACK, 1);
        step(); iIF_REQ = 1'b0;

        // T6: reset with three reads outstanding; late returns must be ignored
        for (int i = 0; i < 3; i++) begin
            iIF_ENA = 1'b1; iIF_RW = 1'b0; iIF_ADDR = 23'h400 + 23'(i);
            @(negedge iCLOCK); check($sformatf("t6_rd%0d_busy", i), oIF_BUSY, 0);
            step();
        end
        iIF_ADDR = 23'h403;
        inRESET = 1'b0;
        exp_q.delete();
        @(negedge iCLOCK);
        check("t6_rst_ack", oIF_ACK, 0);
        check("t6_rst_break", oIF_BREAK, 0);
        check("t6_rst_gnt", oPRI_GNT, 0);
        check("t6_rst_valid", oIF_VALID, 0);
        check("t6_rst_data", oIF_DATA, 0);
        check("t6_rst_mem_ena", oMEM_ENA, 0);
        check("t6_rst_mem_addr", oMEM_ADDR, 0);
        step();
        step(); inRESET = 1'b1; iIF_ENA = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge iCLOCK); check($sformatf("t6_late_valid%0d", i), oIF_VALID, 0);
            step();
        end
        check("t6_late_returns_sent", 64'(pend_q.size()), 0);

        // Counters cleared: a fresh session gets full credit
        mem_lat = 3;
        iIF_REQ = 1'b1;
        step(); iIF_REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            iIF_ENA = 1'b1; iIF_RW = 1'b0; iIF_ADDR = 23'h500 + 23'(i);
            @(negedge iCLOCK); check($sformatf("t6_post_rd%0d_busy", i), oIF_BUSY, 0);
        end
        step(); iIF_ENA = 1'b0;
        wait_drain("t6_post_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
